uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer_pkg.sv | 45 ++++
 rtl/uart_rx_framer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_rx_framer_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_framer_pkg
//
// Shared UART parameters and types. These are used by the receive framer
// (uart_rx_framer) and by the oversampler that feeds it.
//
// Contents:
//   UART_DATA_BITS       default number of data bits per frame (5..8)
//   UART_PARITY_EN       default parity enable (0 = none, 1 = one parity bit)
//   UART_PARITY_ODD      default parity sense (0 = even, 1 = odd)
//   UART_OVERSAMPLE      oversampler clocks per bit
//   UART_MAJORITY_TAPS   oversampler samples per majority vote
//   rx_state_t           2-bit framer state encoding
//   parity_mismatch()    parity check on the running XOR
// ---------------------------------------------------------------------------
package uart_rx_framer_pkg;

    // Framer defaults
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_PARITY_EN  = 0;
    localparam int UART_PARITY_ODD = 0;

    // Oversampler parameters
    localparam int UART_OVERSAMPLE    = 16;
    localparam int UART_MAJORITY_TAPS = 3;

    // Framer states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_PARITY = 2'b10,
        ST_STOP   = 2'b11
    } rx_state_t;

    // The accumulator holds the XOR of all data bits. With a correct
    // parity bit, acc ^ pbit equals 0 for even parity and 1 for odd
    // parity. XORing in the parity sense therefore leaves 1 only on a
    // mismatch.
    function automatic logic parity_mismatch(input logic acc,
                                             input logic pbit,
                                             input logic odd);
        return acc ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_framer.sv
// ---------------------------------------------------------------------------
// uart_rx_framer
//
// Assembles majority-voted bits from the UART oversampler into data words.
// Frame format: start bit, DATA_BITS data bits (LSB first),
// an optional parity bit, and one stop bit.
//
// Parameters:
//   DATA_BITS   data bits per frame, 5..8
//   PARITY_EN   1 adds a parity bit after the data bits
//   PARITY_ODD  1 selects odd parity, 0 selects even parity
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   bit_in        voted bit from the oversampler
//   bit_valid     one-cycle strobe qualifying bit_in
//   sampler_stop  one-cycle pulse that sends the oversampler back to
//                 start-bit search
//   data_out      received word, held until the next data_valid
//   data_valid    one-cycle strobe qualifying data_out and the error flags
//   parity_err    parity mismatch on the delivered word
//   frame_err     stop bit was sampled as 0 (the word is still delivered)
//   busy          high whenever the framer is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int PARITY_EN  = UART_PARITY_EN,
    parameter int PARITY_ODD = UART_PARITY_ODD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 sampler_stop,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    // The counter must hold the value DATA_BITS itself, so it never wraps
    // inside a frame.
    localparam int                CNT_W      = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic              HAS_PARITY = (PARITY_EN != 0);
    localparam logic              ODD_SENSE  = (PARITY_ODD != 0);

    rx_state_t            state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_acc;
    logic                 parity_bad;
    logic                 accept;

    // The oversampler restarts its search in the cycle after we pulse
    // sampler_stop. A strobe that arrives while the pulse is still high
    // belongs to the old bit stream, so it is dropped.
    assign accept = bit_valid & ~sampler_stop;

    // Framer FSM. State and every output are registered in this one block.
    // The state advances only on an accepted strobe.
    // The shift register fills from the MSB end. After DATA_BITS shifts,
    // the first bit on the line sits in bit 0.
    // parity_bad is an internal copy of the parity result. It is moved to
    // parity_err only at the stop bit, so the visible flags always change
    // together with data_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parity_acc   <= 1'b0;
            parity_bad   <= 1'b0;
            sampler_stop <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            sampler_stop <= 1'b0;
            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            state      <= ST_DATA;
                            bit_cnt    <= '0;
                            parity_acc <= 1'b0;
                            parity_bad <= 1'b0;
                            busy       <= 1'b1;
                        end else begin
                            sampler_stop <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_reg  <= {bit_in, shift_reg[DATA_BITS-1:1]};
                        parity_acc <= parity_acc ^ bit_in;
                        bit_cnt    <= bit_cnt + CNT_ONE;
                        if (bit_cnt == LAST_BIT) begin
                            state <= HAS_PARITY ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        parity_bad <= parity_mismatch(parity_acc, bit_in, ODD_SENSE);
                        state      <= ST_STOP;
                    end
                    ST_STOP: begin
                        data_out     <= shift_reg;
                        frame_err    <= ~bit_in;
                        parity_err   <= HAS_PARITY & parity_bad;
                        data_valid   <= 1'b1;
                        sampler_stop <= 1'b1;
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
